fgen_sequencer: RTL
===================

# fgen_sequencer

Parametrised waveform sequencer that replaces the fixed 14-bit, 256-entry, single-shot generator path. It sits between the SPI word assembler (32-bit command words) and the DAC sample FIFO. It decodes commands, stores samples in internal waveform RAM, and streams a programmable-length waveform, repeated a programmable number of times or forever, over a valid/ready interface. It adds burst/loop modes, an explicit STOP, command error reporting and full backpressure handling.

## Interface
- DATA_W, 14, sample width (1..16)
- ADDR_W, 8, waveform RAM address width; depth = 2^ADDR_W (1..12)
- LOOP_W, 16, loop-count width (1..16)
- clk  in  1  single clock (100 MHz domain)
- rst  in  1  reset; one clock, reset is synchronous and active-high
- cmd_valid  in  1  one-cycle strobe, command word present
- cmd_data  in  32  [31:28] opcode, [27:0] payload
- out_data  out  DATA_W  sample to DAC FIFO
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts (driven as !fifo_almost_full)
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse when the finite burst completes
- cmd_err  out  1  one-cycle pulse on a rejected command
- loop_count  out  LOOP_W  completed passes in the current run

## Operation
- Opcodes:
  - 0 NOP.
  - 1 WRITE: RAM[payload[ADDR_W+15:16]] <= payload[DATA_W-1:0].
  - 2 SET_LEN: length <= payload[ADDR_W:0], valid range 1..2^ADDR_W.
  - 3 SET_LOOPS: loops <= payload[LOOP_W-1:0]; 0 = infinite.
  - 4 START.
  - 5 STOP.
  - 6..15: cmd_err.
- States: IDLE, RUN.
  - IDLE --START, length in range--> RUN.
  - RUN --STOP--> IDLE.
  - RUN --last sample of final pass accepted--> IDLE, with done pulse.
- In RUN, commands other than STOP and NOP are ignored and pulse cmd_err. SET_LEN outside 1..2^ADDR_W pulses cmd_err and leaves length unchanged. START with length 0 pulses cmd_err and stays in IDLE.
- Read address runs 0..length-1, then wraps to 0. loop_count increments on acceptance of sample length-1. Finite run ends when loop_count reaches loops. loop_count saturates at its maximum value when loops=0.
- loop_count clears on START. Its value is held after the run ends.
- RAM: synchronous single-port, 1-cycle read latency, not reset. Contents survive rst and STOP.
- Output stage: registered output plus a 1-entry skid buffer. No sample is dropped or duplicated under any out_ready pattern. out_data is stable while out_valid && !out_ready.
- STOP: out_valid is low the next cycle. In-flight and skid samples are discarded. No done pulse.

## Timing
- Reset values:
  - out_data 0, out_valid 0, busy 0, done 0, cmd_err 0, loop_count 0.
  - length 0, loops 0, state IDLE.
- WRITE accepted at edge N; RAM content is visible to a read issued from edge N+1.
- START at edge N: busy=1 after N. First out_valid=1 after edge N+3.
- With out_ready held high, one sample per cycle with no gaps, including across wrap.
- out_ready low for k cycles stalls the stream exactly k cycles. Resuming produces no gap beyond 1 cycle.
- done asserts the cycle after the final transfer, together with busy=0 and out_valid=0.
- cmd_err asserts the cycle after the offending cmd_valid.
- rst mid-RUN: all outputs are at reset values after the edge. The next START restarts from address 0.

## Test plan
- Write RAM[0..3]=10,20,30,40; SET_LEN 4; SET_LOOPS 2; START, out_ready=1. Required: out_data 10,20,30,40,10,20,30,40 on consecutive cycles beginning 3 cycles after START; done pulses once; loop_count=2.
- Same program, out_ready toggled pseudo-randomly. Required: identical accepted sequence with no loss or duplicates; out_data stable during stalls.
- SET_LOOPS 0; START; run 1000 cycles; STOP. Required: periodic 10,20,30,40 stream; out_valid=0 the cycle after STOP; no done pulse.
- Error cases. Required: each of the following pulses cmd_err and changes no state:
  - opcode 9;
  - SET_LEN 0;
  - SET_LEN 2^ADDR_W+1;
  - START with length 0;
  - WRITE during RUN.
- Full depth: ADDR_W=8, length 256. Required: address wrap 255->0 shows no bubble.
- rst asserted mid-RUN. Required: all outputs 0; RAM contents preserved; a new START replays from sample 0.

Source files
------------

// File: rtl/fgen_sequencer.sv
`timescale 1ns/1ps
// fgen_sequencer
// Command-driven waveform sequencer. Decodes 32-bit command words from the
// SPI word assembler, stores samples in an internal waveform RAM, and streams
// a programmable-length waveform a programmable number of times (or forever)
// to the DAC sample FIFO over a valid/ready interface.
//
// Ports:
//   clk         single clock
//   rst         synchronous, active-high reset
//   cmd_valid   one-cycle strobe, command word present on cmd_data
//   cmd_data    [31:28] opcode, [27:0] payload
//   out_data    sample to the DAC FIFO
//   out_valid   out_data holds a sample
//   out_ready   downstream accepts the sample this cycle
//   busy        high while a waveform is running
//   done        one-cycle pulse when a finite burst completes
//   cmd_err     one-cycle pulse when a command is rejected
//   loop_count  completed passes in the current run
module fgen_sequencer #(
   parameter int DATA_W = 14,
   parameter int ADDR_W = 8,
   parameter int LOOP_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   input  logic [31:0]       cmd_data,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done,
   output logic              cmd_err,
   output logic [LOOP_W-1:0] loop_count
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [3:0] OP_NOP       = 4'd0;
   localparam logic [3:0] OP_WRITE     = 4'd1;
   localparam logic [3:0] OP_SET_LEN   = 4'd2;
   localparam logic [3:0] OP_SET_LOOPS = 4'd3;
   localparam logic [3:0] OP_START     = 4'd4;
   localparam logic [3:0] OP_STOP      = 4'd5;

   localparam logic [ADDR_W:0]   DEPTH    = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0]   LEN_ONE  = 1;
   localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
   localparam logic [LOOP_W-1:0] LOOP_ONE = 1;

   state_t              state_q, state_d;
   logic [ADDR_W:0]     length_q, length_d;
   logic [LOOP_W-1:0]   loops_q, loops_d;
   logic [LOOP_W-1:0]   loopCount_q, loopCount_d;
   logic [ADDR_W-1:0]   rdAddr_q, rdAddr_d;
   logic                primed_q, primed_d;
   logic                ramValid_q, ramValid_d;
   logic                ramLast_q, ramLast_d;
   logic                outValid_q, outValid_d;
   logic [DATA_W-1:0]   outData_q, outData_d;
   logic                outLast_q, outLast_d;
   logic                skidValid_q, skidValid_d;
   logic [DATA_W-1:0]   skidData_q, skidData_d;
   logic                skidLast_q, skidLast_d;
   logic                done_q, done_d;
   logic                cmdErr_q, cmdErr_d;

   logic [DATA_W-1:0]   ram [2**ADDR_W];
   logic [DATA_W-1:0]   ramRdData;
   logic [ADDR_W-1:0]   ramAddr;
   logic                ramWe;
   logic                flush;

   logic [3:0]          opcode;
   logic [ADDR_W:0]     newLen;
   logic [ADDR_W-1:0]   wrAddr;
   logic [DATA_W-1:0]   wrData;
   logic                lenOk;
   logic                pop;
   logic                lastPop;
   logic                finalPop;
   logic [1:0]          occupancy;
   logic                canIssue;
   logic                issueLast;
   logic                unusedCmd;

   assign opcode = cmd_data[31:28];
   assign newLen = cmd_data[ADDR_W:0];
   assign wrAddr = cmd_data[ADDR_W+15:16];
   assign wrData = cmd_data[DATA_W-1:0];
   assign lenOk  = (newLen != '0) && (newLen <= DEPTH);

   // Payload bits outside the decoded fields are don't-care; this reduction
   // only marks them as deliberately ignored.
   assign unusedCmd = ^cmd_data;

   assign pop       = outValid_q && out_ready;
   assign lastPop   = pop && outLast_q;
   assign finalPop  = lastPop && (loops_q != '0) && ((loopCount_q + LOOP_ONE) == loops_q);
   assign issueLast = ({1'b0, rdAddr_q} == (length_q - LEN_ONE));

   // A read issued now lands in the output/skid pair on the next edge. Only
   // issue when, after this edge's landing and pop, at most one slot is
   // taken, so the landing always has a free slot even if out_ready drops.
   assign occupancy = {1'b0, outValid_q} + {1'b0, skidValid_q} + {1'b0, ramValid_q} - {1'b0, pop};
   assign canIssue  = (occupancy <= 2'd1);

   // Single-port waveform RAM. Writes only happen in IDLE and reads only in
   // RUN, so one shared address port is enough. Deliberately not reset.
   always_ff @(posedge clk) begin
      if (ramWe) begin
         ram[ramAddr] <= wrData;
      end
      ramRdData <= ram[ramAddr];
   end

   // Next-state logic: output/skid buffering, read issue, loop counting,
   // command decode and the IDLE/RUN state machine.
   always_comb begin
      state_d     = state_q;
      length_d    = length_q;
      loops_d     = loops_q;
      loopCount_d = loopCount_q;
      rdAddr_d    = rdAddr_q;
      primed_d    = primed_q;
      ramValid_d  = 1'b0;
      ramLast_d   = ramLast_q;
      outValid_d  = outValid_q;
      outData_d   = outData_q;
      outLast_d   = outLast_q;
      skidValid_d = skidValid_q;
      skidData_d  = skidData_q;
      skidLast_d  = skidLast_q;
      done_d      = 1'b0;
      cmdErr_d    = 1'b0;
      ramWe       = 1'b0;
      ramAddr     = rdAddr_q;
      flush       = 1'b0;

      if (pop) begin
         if (skidValid_q) begin
            outValid_d  = 1'b1;
            outData_d   = skidData_q;
            outLast_d   = skidLast_q;
            skidValid_d = ramValid_q;
            if (ramValid_q) begin
               skidData_d = ramRdData;
               skidLast_d = ramLast_q;
            end
         end else begin
            outValid_d = ramValid_q;
            if (ramValid_q) begin
               outData_d = ramRdData;
               outLast_d = ramLast_q;
            end
         end
      end else if (!outValid_q) begin
         outValid_d = ramValid_q;
         if (ramValid_q) begin
            outData_d = ramRdData;
            outLast_d = ramLast_q;
         end
      end else if (ramValid_q) begin
         skidValid_d = 1'b1;
         skidData_d  = ramRdData;
         skidLast_d  = ramLast_q;
      end

      if ((state_q == RUN) && primed_q && canIssue) begin
         ramValid_d = 1'b1;
         ramLast_d  = issueLast;
         rdAddr_d   = issueLast ? '0 : rdAddr_q + ADDR_ONE;
      end

      if (lastPop && !(&loopCount_q)) begin
         loopCount_d = loopCount_q + LOOP_ONE;
      end

      case (state_q)
         IDLE: begin
            primed_d = 1'b0;
            if (cmd_valid) begin
               case (opcode)
                  OP_NOP, OP_STOP: begin
                  end
                  OP_WRITE: begin
                     ramWe   = 1'b1;
                     ramAddr = wrAddr;
                  end
                  OP_SET_LEN: begin
                     if (lenOk) length_d = newLen;
                     else       cmdErr_d = 1'b1;
                  end
                  OP_SET_LOOPS: begin
                     loops_d = cmd_data[LOOP_W-1:0];
                  end
                  OP_START: begin
                     if (length_q != '0) begin
                        state_d     = RUN;
                        rdAddr_d    = '0;
                        loopCount_d = '0;
                     end else begin
                        cmdErr_d = 1'b1;
                     end
                  end
                  default: cmdErr_d = 1'b1;
               endcase
            end
         end
         RUN: begin
            // The first RUN cycle only primes the read pipe, which puts the
            // first valid sample three edges after START.
            primed_d = 1'b1;
            if (cmd_valid && (opcode != OP_NOP) && (opcode != OP_STOP)) begin
               cmdErr_d = 1'b1;
            end
            if (cmd_valid && (opcode == OP_STOP)) begin
               flush   = 1'b1;
               state_d = IDLE;
            end else if (finalPop) begin
               flush   = 1'b1;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Reads fetched ahead of the end of a run are speculative; drop them.
      if (flush) begin
         outValid_d  = 1'b0;
         skidValid_d = 1'b0;
         ramValid_d  = 1'b0;
      end
   end

   // State and pipeline registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         length_q    <= '0;
         loops_q     <= '0;
         loopCount_q <= '0;
         rdAddr_q    <= '0;
         primed_q    <= 1'b0;
         ramValid_q  <= 1'b0;
         ramLast_q   <= 1'b0;
         outValid_q  <= 1'b0;
         outData_q   <= '0;
         outLast_q   <= 1'b0;
         skidValid_q <= 1'b0;
         skidData_q  <= '0;
         skidLast_q  <= 1'b0;
         done_q      <= 1'b0;
         cmdErr_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         length_q    <= length_d;
         loops_q     <= loops_d;
         loopCount_q <= loopCount_d;
         rdAddr_q    <= rdAddr_d;
         primed_q    <= primed_d;
         ramValid_q  <= ramValid_d;
         ramLast_q   <= ramLast_d;
         outValid_q  <= outValid_d;
         outData_q   <= outData_d;
         outLast_q   <= outLast_d;
         skidValid_q <= skidValid_d;
         skidData_q  <= skidData_d;
         skidLast_q  <= skidLast_d;
         done_q      <= done_d;
         cmdErr_q    <= cmdErr_d;
      end
   end

   assign out_data   = outData_q;
   assign out_valid  = outValid_q;
   assign busy       = (state_q == RUN);
   assign done       = done_q;
   assign cmd_err    = cmdErr_q;
   assign loop_count = loopCount_q;

endmodule
